// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 3x3 keypad scanner.
// Holds the matrix geometry, the FSM state encoding and the frame class encoding.
package keypad_pkg;

  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam logic [3:0] KEY_NONE = 4'd0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    FRAME_NONE   = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_class_e;

  function automatic logic [1:0] col_count(input logic [COLS-1:0] cols);
    return {1'b0, cols[0]} + {1'b0, cols[1]} + {1'b0, cols[2]};
  endfunction

  // Highest set column wins, so the frame keeps the last code found in scan order.
  function automatic logic [1:0] last_col(input logic [COLS-1:0] cols);
    logic [1:0] col_v;
    if (cols[2]) begin
      col_v = 2'd2;
    end else if (cols[1]) begin
      col_v = 2'd1;
    end else begin
      col_v = 2'd0;
    end
    return col_v;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_col_sync.sv
// Two-flop synchroniser for the asynchronous column returns.
// Synchronous active-high reset clears both stages.
module keypad_col_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] async_cols,
  output logic [WIDTH-1:0] sync_cols
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage capture of the column pins.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= async_cols;
      sync_r <= meta_r;
    end
  end

  assign sync_cols = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 keypad scanner: row strobing, per-frame key accumulation and a
// debounce/hold FSM that emits a validated key code with a one-cycle pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic [COLS-1:0] coluna_in,
  output logic [ROWS-1:0] linha_out,
  output logic [3:0]      key_code_out,
  output logic            key_valid_out,
  output logic            key_held_out,
  output logic            multi_key_out
);

  localparam logic [7:0] SLOT_LAST = 8'(SCAN_CYCLES - 1);
  localparam logic [3:0] DB_FRAMES = 4'(DEBOUNCE_FRAMES);

  logic [COLS-1:0] col_sync_s;
  logic [7:0]      slot_r;
  logic [1:0]      row_r;
  logic [ROWS-1:0] linha_r;
  logic [1:0]      key_cnt_r;
  logic [3:0]      code_r;
  logic            slot_end_s;
  logic            frame_end_s;
  logic [2:0]      key_sum_s;
  logic [1:0]      frame_keys_s;
  logic [3:0]      frame_code_s;
  frame_class_e    frame_class_s;
  scan_state_e     state_r;
  scan_state_e     state_nx_s;
  logic [3:0]      cand_r;
  logic [3:0]      cand_nx_s;
  logic [3:0]      cnt_r;
  logic [3:0]      cnt_nx_s;
  logic [3:0]      cnt_inc_s;
  logic            accept_s;
  logic            multi_s;
  logic            held_s;
  logic [3:0]      key_code_r;
  logic            key_valid_r;
  logic            key_held_r;
  logic            multi_key_r;

  keypad_col_sync #(.WIDTH(COLS)) u_col_sync (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .async_cols (coluna_in),
    .sync_cols  (col_sync_s)
  );

  assign slot_end_s  = (slot_r == SLOT_LAST);
  assign frame_end_s = slot_end_s && (row_r == 2'd2);

  // Slot counter and one-hot row strobe.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      slot_r  <= 8'd0;
      row_r   <= 2'd0;
      linha_r <= 3'b001;
    end else if (slot_end_s) begin
      slot_r <= 8'd0;
      if (row_r == 2'd2) begin
        row_r   <= 2'd0;
        linha_r <= 3'b001;
      end else begin
        row_r   <= row_r + 2'd1;
        linha_r <= linha_r << 1;
      end
    end else begin
      slot_r <= slot_r + 8'd1;
    end
  end

  // Fold the current slot's sample into the running frame totals.
  always_comb begin
    key_sum_s    = {1'b0, key_cnt_r} + {1'b0, col_count(col_sync_s)};
    frame_keys_s = (key_sum_s >= 3'd2) ? 2'd2 : key_sum_s[1:0];
    if (col_sync_s != 3'b000) begin
      frame_code_s = key_code(row_r, last_col(col_sync_s));
    end else begin
      frame_code_s = code_r;
    end
    case (frame_keys_s)
      2'd0:    frame_class_s = FRAME_NONE;
      2'd1:    frame_class_s = FRAME_SINGLE;
      default: frame_class_s = FRAME_MULTI;
    endcase
  end

  // Frame accumulator, cleared at the end of every frame.
  always_ff @(posedge clock_in) begin
    if (reset_in || frame_end_s) begin
      key_cnt_r <= 2'd0;
      code_r    <= KEY_NONE;
    end else if (slot_end_s) begin
      key_cnt_r <= frame_keys_s;
      code_r    <= frame_code_s;
    end else begin
      key_cnt_r <= key_cnt_r;
      code_r    <= code_r;
    end
  end

  // FSM state register with candidate and frame counter.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_r <= IDLE;
      cand_r  <= KEY_NONE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      cand_r  <= cand_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  assign cnt_inc_s = cnt_r + 4'd1;

  // Next-state logic; only end-of-frame classifications move the FSM.
  always_comb begin
    state_nx_s = state_r;
    cand_nx_s  = cand_r;
    cnt_nx_s   = cnt_r;
    if (frame_end_s) begin
      case (state_r)
        IDLE: begin
          if (frame_class_s == FRAME_SINGLE) begin
            cand_nx_s = frame_code_s;
            if (DB_FRAMES == 4'd1) begin
              state_nx_s = HELD;
              cnt_nx_s   = 4'd0;
            end else begin
              state_nx_s = DEBOUNCE;
              cnt_nx_s   = 4'd1;
            end
          end else begin
            state_nx_s = IDLE;
          end
        end
        DEBOUNCE: begin
          if ((frame_class_s == FRAME_SINGLE) && (frame_code_s == cand_r)) begin
            if (cnt_inc_s >= DB_FRAMES) begin
              state_nx_s = HELD;
              cnt_nx_s   = 4'd0;
            end else begin
              cnt_nx_s = cnt_inc_s;
            end
          end else begin
            state_nx_s = IDLE;
            cnt_nx_s   = 4'd0;
          end
        end
        HELD: begin
          if (frame_class_s == FRAME_NONE) begin
            if (DB_FRAMES == 4'd1) begin
              state_nx_s = IDLE;
              cnt_nx_s   = 4'd0;
            end else begin
              state_nx_s = RELEASE;
              cnt_nx_s   = 4'd1;
            end
          end else begin
            state_nx_s = HELD;
          end
        end
        RELEASE: begin
          if (frame_class_s == FRAME_NONE) begin
            if (cnt_inc_s >= DB_FRAMES) begin
              state_nx_s = IDLE;
              cnt_nx_s   = 4'd0;
            end else begin
              cnt_nx_s = cnt_inc_s;
            end
          end else begin
            state_nx_s = HELD;
            cnt_nx_s   = 4'd0;
          end
        end
        default: begin
          state_nx_s = IDLE;
          cnt_nx_s   = 4'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Output decode: an accept is any frame-end entry into HELD from a non-held state.
  always_comb begin
    accept_s = frame_end_s && (state_nx_s == HELD) &&
               ((state_r == IDLE) || (state_r == DEBOUNCE));
    multi_s  = frame_end_s && (frame_class_s == FRAME_MULTI);
    held_s   = (state_nx_s == HELD) || (state_nx_s == RELEASE);
  end

  // Registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      key_code_r  <= KEY_NONE;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
      multi_key_r <= 1'b0;
    end else begin
      key_valid_r <= accept_s;
      key_held_r  <= held_s;
      multi_key_r <= multi_s;
      if (accept_s) begin
        key_code_r <= frame_code_s;
      end else begin
        key_code_r <= key_code_r;
      end
    end
  end

  assign linha_out     = linha_r;
  assign key_code_out  = key_code_r;
  assign key_valid_out = key_valid_r;
  assign key_held_out  = key_held_r;
  assign multi_key_out = multi_key_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Table-driven bench for keypad_scanner (SCAN_CYCLES=4, DEBOUNCE_FRAMES=3).
// A behavioural keypad returns the pressed columns while the pressed row is strobed.
module tb_keypad_scanner;

  localparam int FRAME = 12;

  typedef struct {
    int         rst_cycles;
    logic [1:0] row;
    logic [2:0] cols;
    int         frames;
    int         exp_valid;
    int         exp_multi;
    logic [3:0] exp_code;
    logic       exp_held;
  } vec_t;

  logic       clock_in = 1'b0;
  logic       reset_in = 1'b0;
  logic [2:0] coluna_in;
  logic [2:0] linha_out;
  logic [3:0] key_code_out;
  logic       key_valid_out;
  logic       key_held_out;
  logic       multi_key_out;

  logic       force_all = 1'b0;
  logic [1:0] kp_row = 2'd0;
  logic [2:0] kp_cols = 3'b000;

  int checks = 0;
  int errors = 0;

  vec_t vecs [18];

  always #10 clock_in = ~clock_in;

  assign coluna_in = force_all ? 3'b111 : (linha_out[kp_row] ? kp_cols : 3'b000);

  keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_FRAMES(3)) dut (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .coluna_in     (coluna_in),
    .linha_out     (linha_out),
    .key_code_out  (key_code_out),
    .key_valid_out (key_valid_out),
    .key_held_out  (key_held_out),
    .multi_key_out (multi_key_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clock_in);
      #1;
      check("reset_outputs",
            {25'd0, linha_out, key_code_out, key_valid_out, key_held_out, multi_key_out},
            {25'd0, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0});
    end
    reset_in = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n_valid;
    int n_multi;
    int n_both;
    int valid_at;
    n_valid  = 0;
    n_multi  = 0;
    n_both   = 0;
    valid_at = -1;
    kp_row   = v.row;
    kp_cols  = v.cols;
    if (v.rst_cycles > 0) begin
      do_reset(v.rst_cycles);
    end
    for (int c = 0; c < v.frames * FRAME; c++) begin
      @(posedge clock_in);
      #1;
      if (key_valid_out === 1'b1) begin
        n_valid++;
        valid_at = c;
      end
      if (multi_key_out === 1'b1) n_multi++;
      if ((key_valid_out === 1'b1) && (multi_key_out === 1'b1)) n_both++;
    end
    check($sformatf("v%0d_valid_pulses", idx), n_valid, v.exp_valid);
    check($sformatf("v%0d_multi_pulses", idx), n_multi, v.exp_multi);
    check($sformatf("v%0d_valid_and_multi", idx), n_both, 0);
    check($sformatf("v%0d_key_code", idx), {28'd0, key_code_out}, {28'd0, v.exp_code});
    check($sformatf("v%0d_key_held", idx), {31'd0, key_held_out}, {31'd0, v.exp_held});
    if (v.exp_valid == 1) begin
      check($sformatf("v%0d_valid_latency", idx), valid_at, v.frames * FRAME - 1);
    end
  endtask

  initial begin
    // rst, row, cols, frames, valid, multi, code, held
    vecs[0]  = '{5, 2'd2, 3'b010, 3, 1, 0, 4'd8, 1'b1};
    vecs[1]  = '{0, 2'd2, 3'b010, 2, 0, 0, 4'd8, 1'b1};
    vecs[2]  = '{0, 2'd2, 3'b000, 2, 0, 0, 4'd8, 1'b1};
    vecs[3]  = '{0, 2'd2, 3'b000, 1, 0, 0, 4'd8, 1'b0};
    vecs[4]  = '{5, 2'd0, 3'b001, 1, 0, 0, 4'd0, 1'b0};
    vecs[5]  = '{0, 2'd0, 3'b000, 1, 0, 0, 4'd0, 1'b0};
    vecs[6]  = '{0, 2'd0, 3'b001, 1, 0, 0, 4'd0, 1'b0};
    vecs[7]  = '{0, 2'd0, 3'b000, 3, 0, 0, 4'd0, 1'b0};
    vecs[8]  = '{5, 2'd0, 3'b101, 5, 0, 5, 4'd0, 1'b0};
    vecs[9]  = '{0, 2'd0, 3'b001, 3, 1, 0, 4'd1, 1'b1};
    vecs[10] = '{5, 2'd1, 3'b010, 3, 1, 0, 4'd5, 1'b1};
    vecs[11] = '{0, 2'd1, 3'b000, 1, 0, 0, 4'd5, 1'b1};
    vecs[12] = '{0, 2'd1, 3'b010, 1, 0, 0, 4'd5, 1'b1};
    vecs[13] = '{0, 2'd1, 3'b000, 3, 0, 0, 4'd5, 1'b0};
    vecs[14] = '{0, 2'd1, 3'b010, 3, 1, 0, 4'd5, 1'b1};
    vecs[15] = '{5, 2'd2, 3'b100, 2, 0, 0, 4'd0, 1'b0};
    vecs[16] = '{1, 2'd2, 3'b100, 2, 0, 0, 4'd0, 1'b0};
    vecs[17] = '{0, 2'd2, 3'b100, 1, 1, 0, 4'd9, 1'b1};

    // Reset with every column asserted, then the free-running row strobe.
    @(negedge clock_in);
    force_all = 1'b1;
    do_reset(5);
    force_all = 1'b0;
    check("row_after_release", {29'd0, linha_out}, {29'd0, 3'b001});
    for (int k = 1; k <= 3 * FRAME; k++) begin
      logic [2:0] exp_row;
      @(posedge clock_in);
      #1;
      exp_row = 3'b001 << ((k / 4) % 3);
      check($sformatf("row_strobe_k%0d", k), {29'd0, linha_out}, {29'd0, exp_row});
    end

    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i], i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
